// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding controller: forward-select codes,
// producer classes, use-time constants and the scoreboard entry type.
package hazard_ctrl_pkg;

    localparam int unsigned ADDR_W = 5;  // register address width
    localparam int unsigned TNEW_W = 2;  // width of Tnew/Tuse fields

    // Forward-select encoding shared by CMPAfor, CMPBfor and Rafor
    localparam logic [2:0] FWD_GRF     = 3'd0;
    localparam logic [2:0] FWD_ALU_MEM = 3'd1;
    localparam logic [2:0] FWD_WD_WB   = 3'd2;
    localparam logic [2:0] FWD_PC8_EX  = 3'd3;
    localparam logic [2:0] FWD_PC8_MEM = 3'd4;
    localparam logic [2:0] FWD_PC8_WB  = 3'd5;

    // Producer classes
    localparam logic [1:0] SRC_ALU  = 2'd0;
    localparam logic [1:0] SRC_LOAD = 2'd1;
    localparam logic [1:0] SRC_LINK = 2'd2;

    // Use-time meaning "operand not read"; never exceeded by any Tnew
    localparam logic [TNEW_W-1:0] TUSE_NONE = 2'd3;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] wa;
        logic [TNEW_W-1:0] tnew;
        logic [1:0]        src;
    } sb_entry_t;

    // Cycles until the result exists, counted from entry into EX
    function automatic logic [TNEW_W-1:0] tnew_of(input logic [1:0] src);
        logic [TNEW_W-1:0] t;
        case (src)
            SRC_ALU:  t = 2'd1;
            SRC_LOAD: t = 2'd2;
            default:  t = 2'd0;
        endcase
        return t;
    endfunction

    // Advance an entry by one stage; Tnew saturates at zero
    function automatic sb_entry_t age_entry(input sb_entry_t e);
        sb_entry_t r;
        r = e;
        if (e.tnew != '0) begin
            r.tnew = e.tnew - 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_pick.sv
// Per-operand hazard check: finds the youngest scoreboard hit for one source
// register, decides whether decode must stall and which forward path to use.
module hazard_ctrl_fwd_pick
    import hazard_ctrl_pkg::*;
(
    input  sb_entry_t         i_ex,
    input  sb_entry_t         i_mem,
    input  sb_entry_t         i_wb,
    input  logic [ADDR_W-1:0] i_reg,
    input  logic [TNEW_W-1:0] i_tuse,
    output logic              o_stall,
    output logic [2:0]        o_sel
);

    logic w_hit_ex;
    logic w_hit_mem;
    logic w_hit_wb;

    // $0 is hard-wired, so it never matches a producer
    assign w_hit_ex  = i_ex.valid  && (i_ex.wa  == i_reg) && (i_reg != '0);
    assign w_hit_mem = i_mem.valid && (i_mem.wa == i_reg) && (i_reg != '0);
    assign w_hit_wb  = i_wb.valid  && (i_wb.wa  == i_reg) && (i_reg != '0);

    // Stall if any hit is produced later than needed; select from youngest hit only
    always_comb begin
        o_stall = (w_hit_ex  && (i_ex.tnew  > i_tuse)) ||
                  (w_hit_mem && (i_mem.tnew > i_tuse)) ||
                  (w_hit_wb  && (i_wb.tnew  > i_tuse));
        o_sel = FWD_GRF;
        if (w_hit_ex) begin
            if (i_ex.tnew == '0 && i_ex.src == SRC_LINK) begin
                o_sel = FWD_PC8_EX;
            end
        end else if (w_hit_mem) begin
            if (i_mem.tnew == '0) begin
                o_sel = (i_mem.src == SRC_LINK) ? FWD_PC8_MEM : FWD_ALU_MEM;
            end
        end else if (w_hit_wb) begin
            if (i_wb.tnew == '0) begin
                o_sel = (i_wb.src == SRC_LINK) ? FWD_PC8_WB : FWD_WD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline. Tracks in-flight
// register writers in an EX/MEM/WB scoreboard and drives decode stall, EX bubble
// and forward selects. Define HAZARD_STATS_EN to add the stall_cnt output.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_ID,
    input  logic [ADDR_W-1:0] rt_ID,
    input  logic [TNEW_W-1:0] tuse_rs_ID,
    input  logic [TNEW_W-1:0] tuse_rt_ID,
    input  logic [ADDR_W-1:0] wa_ID,
    input  logic [1:0]        src_ID,
    output logic              stall,
    output logic              bubble_EX,
    output logic [2:0]        CMPAfor,
    output logic [2:0]        CMPBfor,
    output logic [2:0]        Rafor
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    sb_entry_t  r_ex;
    sb_entry_t  r_mem;
    sb_entry_t  r_wb;
    sb_entry_t  w_ex_d;
    logic       w_stall_rs;
    logic       w_stall_rt;
    logic       w_stall;
    logic [2:0] w_sel_rs;
    logic [2:0] w_sel_rt;

    hazard_ctrl_fwd_pick u_pick_rs (
        .i_ex    (r_ex),
        .i_mem   (r_mem),
        .i_wb    (r_wb),
        .i_reg   (rs_ID),
        .i_tuse  (tuse_rs_ID),
        .o_stall (w_stall_rs),
        .o_sel   (w_sel_rs)
    );

    hazard_ctrl_fwd_pick u_pick_rt (
        .i_ex    (r_ex),
        .i_mem   (r_mem),
        .i_wb    (r_wb),
        .i_reg   (rt_ID),
        .i_tuse  (tuse_rt_ID),
        .o_stall (w_stall_rt),
        .o_sel   (w_sel_rt)
    );

    assign w_stall   = w_stall_rs | w_stall_rt;
    assign stall     = w_stall;
    assign bubble_EX = w_stall;
    assign CMPAfor   = w_sel_rs;
    assign CMPBfor   = w_sel_rt;
    assign Rafor     = w_sel_rs;

    // New EX entry: the decode instruction, or a bubble while decode is held
    always_comb begin
        w_ex_d = '0;
        if (!w_stall) begin
            w_ex_d.valid = (wa_ID != '0);
            w_ex_d.wa    = wa_ID;
            w_ex_d.tnew  = tnew_of(src_ID);
            w_ex_d.src   = src_ID;
        end
    end

    // Scoreboard shift; MEM and WB advance regardless of stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_ex  <= w_ex_d;
            r_mem <= age_entry(r_ex);
            r_wb  <= age_entry(r_mem);
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;

    // Count stalled cycles; wraps naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic against an age-based pipeline model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] rs_ID = '0;
    logic [4:0] rt_ID = '0;
    logic [1:0] tuse_rs_ID = 2'd3;
    logic [1:0] tuse_rt_ID = 2'd3;
    logic [4:0] wa_ID = '0;
    logic [1:0] src_ID = '0;
    logic       stall;
    logic       bubble_EX;
    logic [2:0] CMPAfor;
    logic [2:0] CMPBfor;
    logic [2:0] Rafor;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 0;

    hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .rs_ID      (rs_ID),
        .rt_ID      (rt_ID),
        .tuse_rs_ID (tuse_rs_ID),
        .tuse_rt_ID (tuse_rt_ID),
        .wa_ID      (wa_ID),
        .src_ID     (src_ID),
        .stall      (stall),
        .bubble_EX  (bubble_EX),
        .CMPAfor    (CMPAfor),
        .CMPBfor    (CMPBfor),
        .Rafor      (Rafor)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // pipe[k] is the writer that entered EX k cycles ago (0 = EX, 1 = MEM, 2 = WB).
    typedef struct {
        bit valid;
        int wa;
        int src;
    } slot_t;

    slot_t pipe[3];
    int    m_cnt = 0;

    function automatic int base_tnew(input int src);
        if (src == 0) return 1;
        if (src == 1) return 2;
        return 0;
    endfunction

    function automatic void eval(input int r, input int tuse, output bit st, output int sel);
        bit found;
        int tn;
        st = 0;
        sel = 0;
        found = 0;
        for (int k = 0; k < 3; k++) begin
            if (pipe[k].valid && pipe[k].wa == r && r != 0) begin
                tn = base_tnew(pipe[k].src) - k;
                if (tn < 0) tn = 0;
                if (tn > tuse) st = 1;
                if (!found) begin
                    found = 1;
                    if (tn == 0) sel = (pipe[k].src == 2) ? 3 + k : k;
                end
            end
        end
    endfunction

    always @(posedge clk or negedge reset) begin
        bit s_a, s_b;
        int q_a, q_b;
        if (!reset) begin
            for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0};
            m_cnt = 0;
        end else begin
            eval(int'(rs_ID), int'(tuse_rs_ID), s_a, q_a);
            eval(int'(rt_ID), int'(tuse_rt_ID), s_b, q_b);
            if (s_a || s_b) m_cnt++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (s_a || s_b) pipe[0] = '{0, 0, 0};
            else pipe[0] = '{(wa_ID != 0), int'(wa_ID), int'(src_ID)};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs against the model once per cycle
    always @(negedge clk) begin
        bit s_a, s_b;
        int q_a, q_b;
        if (cmp_en) begin
            eval(int'(rs_ID), int'(tuse_rs_ID), s_a, q_a);
            eval(int'(rt_ID), int'(tuse_rt_ID), s_b, q_b);
            chk("m_stall", {31'd0, stall}, {31'd0, s_a | s_b});
            chk("m_bubble", {31'd0, bubble_EX}, {31'd0, s_a | s_b});
            chk("m_cmpa", {29'd0, CMPAfor}, q_a);
            chk("m_cmpb", {29'd0, CMPBfor}, q_b);
            chk("m_rafor", {29'd0, Rafor}, q_a);
`ifdef HAZARD_STATS_EN
            chk("m_cnt", stall_cnt, m_cnt);
`endif
        end
    end

    // One decode cycle: drive after the edge, return at the following negedge
    task automatic cyc(input int rs, input int rt, input int trs, input int trt,
                       input int wa, input int src);
        @(posedge clk);
        #1;
        rs_ID      = 5'(rs);
        rt_ID      = 5'(rt);
        tuse_rs_ID = 2'(trs);
        tuse_rt_ID = 2'(trt);
        wa_ID      = 5'(wa);
        src_ID     = 2'(src);
        @(negedge clk);
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) cyc(0, 0, 3, 3, 0, 0);
    endtask

    initial begin
        #2 cmp_en = 1;
        #10 reset = 1;  // released between edges

        // reset state
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_cmpa", {29'd0, CMPAfor}, 32'd0);

        // 1: ALU $3 in EX, beq on $3 in decode
        cyc(0, 0, 3, 3, 3, 0);
        cyc(3, 0, 0, 3, 0, 0);
        chk("t1_stall", {31'd0, stall}, 32'd1);
        chk("t1_bubble", {31'd0, bubble_EX}, 32'd1);
        cyc(3, 0, 0, 3, 0, 0);
        chk("t1_cmpa", {29'd0, CMPAfor}, 32'd1);
        chk("t1_nostall", {31'd0, stall}, 32'd0);
        flush();

        // 2: lw $5 then consumer on rt with Tuse 1
        cyc(0, 0, 3, 3, 5, 1);
        cyc(0, 5, 3, 1, 0, 0);
        chk("t2_stall", {31'd0, stall}, 32'd1);
        cyc(0, 5, 3, 1, 0, 0);
        chk("t2_nostall", {31'd0, stall}, 32'd0);
        chk("t2_cmpb0", {29'd0, CMPBfor}, 32'd0);
        cyc(0, 5, 3, 1, 0, 0);
        chk("t2_cmpb", {29'd0, CMPBfor}, 32'd2);
        flush();

        // 3: jal in EX, jr $31
        cyc(0, 0, 3, 3, 31, 2);
        cyc(31, 0, 0, 3, 0, 0);
        chk("t3_rafor_ex", {29'd0, Rafor}, 32'd3);
        chk("t3_nostall", {31'd0, stall}, 32'd0);
        cyc(31, 0, 0, 3, 0, 0);
        chk("t3_rafor_mem", {29'd0, Rafor}, 32'd4);
        chk("t3_cmpa_mem", {29'd0, CMPAfor}, 32'd4);
        flush();

        // 4: writer of $0 never hits
        cyc(0, 0, 3, 3, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t4_stall", {31'd0, stall}, 32'd0);
        chk("t4_cmpa", {29'd0, CMPAfor}, 32'd0);
        chk("t4_cmpb", {29'd0, CMPBfor}, 32'd0);
        flush();

        // 5: $4 in both EX and WB; the younger, unready EX entry wins
        cyc(0, 0, 3, 3, 4, 0);
        cyc(0, 0, 3, 3, 0, 0);
        cyc(0, 0, 3, 3, 4, 0);
        cyc(4, 0, 0, 3, 0, 0);
        chk("t5_stall", {31'd0, stall}, 32'd1);
        chk("t5_cmpa", {29'd0, CMPAfor}, 32'd0);

        // 6: async reset while stalled
        #2 reset = 0;
        #1;
        chk("t6_stall", {31'd0, stall}, 32'd0);
        chk("t6_bubble", {31'd0, bubble_EX}, 32'd0);
        chk("t6_cmpa", {29'd0, CMPAfor}, 32'd0);
`ifdef HAZARD_STATS_EN
        chk("t6_cnt", stall_cnt, 32'd0);
`endif
        #1 reset = 1;

        // randomized traffic with occasional mid-cycle resets
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            rs_ID      = 5'($urandom_range(0, 3));
            rt_ID      = 5'($urandom_range(0, 3));
            tuse_rs_ID = 2'($urandom_range(0, 3));
            tuse_rt_ID = 2'($urandom_range(0, 3));
            wa_ID      = 5'($urandom_range(0, 3));
            src_ID     = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 59) == 0) begin
                #2 reset = 0;
                #4 reset = 1;
            end
        end

        @(negedge clk);
        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
